// File: rtl/uart_byte_rx_if.sv
// Receiver-side bundle for uart_byte_rx: serial line in, byte/strobe/status out.
// data_in_rx is meaningful only in the cycle rx_data_valid is high; there is no ready, so the consumer must take it then.
interface uart_byte_rx_if;
   logic       rx;
   logic [7:0] data_in_rx;
   logic       rx_data_valid;
   logic       frame_err;
   logic       rx_busy;
   logic [2:0] rx_state;

   modport master (
      output rx,
      input  data_in_rx, rx_data_valid, frame_err, rx_busy, rx_state
   );

   modport slave (
      input  rx,
      output data_in_rx, rx_data_valid, frame_err, rx_busy, rx_state
   );
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: double-flop synchronizer, mid-bit sampling FSM, one-cycle
// byte strobe and framing-error pulse. rx_state mirrors the FSM for observation.
module uart_byte_rx #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115_200
) (
   input  logic          clk,
   input  logic          rst,
   uart_byte_rx_if.slave bus
);

   localparam int CPB  = CLK_FREQ / BAUD_RATE;
   localparam int HALF = CPB / 2;
   localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;

   localparam logic [CW-1:0] CNT_BIT_END  = CW'(CPB - 1);
   localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF - 1);

   generate
      if (CPB < 8) begin : g_cpb_too_small
         $error("uart_byte_rx: CLK_FREQ/BAUD_RATE must be at least 8");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [2:0]    bit_idx, bit_idx_nx;
   logic [7:0]    shreg, shreg_nx;
   logic [7:0]    data_q, data_nx;
   logic          valid_q, valid_nx;
   logic          ferr_q, ferr_nx;
   logic          rx_meta, rxs;

   // Two-flop synchronizer; both stages idle high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rxs     <= rx_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         bit_idx <= bit_idx_nx;
         shreg   <= shreg_nx;
         data_q  <= data_nx;
         valid_q <= valid_nx;
         ferr_q  <= ferr_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      bit_idx_nx = bit_idx;
      shreg_nx   = shreg;
      data_nx    = data_q;
      valid_nx   = 1'b0;
      ferr_nx    = 1'b0;

      case (state)
         IDLE: begin
            cnt_nx     = '0;
            bit_idx_nx = '0;
            if (!rxs) state_nx = START;
         end

         START: begin
            if (cnt == CNT_HALF_END) begin
               cnt_nx     = '0;
               bit_idx_nx = '0;
               // A line that is high again at mid-start was a glitch.
               state_nx   = rxs ? IDLE : DATA;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end

         DATA: begin
            if (cnt == CNT_BIT_END) begin
               cnt_nx            = '0;
               shreg_nx[bit_idx] = rxs;
               if (bit_idx == 3'd7) begin
                  bit_idx_nx = '0;
                  state_nx   = STOP;
               end else begin
                  bit_idx_nx = bit_idx + 3'd1;
               end
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end

         STOP: begin
            if (cnt == CNT_BIT_END) begin
               cnt_nx = '0;
               // Leaving at mid-stop lets a start bit right after a one-bit stop be caught.
               if (rxs) begin
                  data_nx  = shreg;
                  valid_nx = 1'b1;
                  state_nx = IDLE;
               end else begin
                  ferr_nx  = 1'b1;
                  state_nx = WAIT_HIGH;
               end
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end

         WAIT_HIGH: begin
            cnt_nx = '0;
            if (rxs) state_nx = IDLE;
         end

         default: begin
            cnt_nx   = '0;
            state_nx = IDLE;
         end
      endcase
   end

   assign bus.data_in_rx    = data_q;
   assign bus.rx_data_valid = valid_q;
   assign bus.frame_err     = ferr_q;
   assign bus.rx_busy       = (state != IDLE);
   assign bus.rx_state      = state;

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(valid_q && ferr_q));
         assert (!(valid_q && valid_nx));
      end
   end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: frame-level reference model, negedge monitor,
// scenario tasks and a small instruction-word assembler model downstream.
module tb_uart_byte_rx;

  localparam int CPB  = 16;
  localparam int HALF = 8;
  // Two synchronizer flops plus the detect edge, then the stop-bit midpoint.
  localparam int LAT  = 3 + HALF + 9 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  uart_byte_rx_if ifc ();

  uart_byte_rx #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [7:0] exp_q[$];
  int         exp_t[$];
  int         exp_fe_t[$];
  logic [7:0] got_q[$];
  int         got_t[$];
  logic       got_busy[$];
  int         got_fe_t[$];
  logic [7:0] fe_data[$];
  int         dbl_cnt = 0;
  int         both_cnt = 0;
  logic       prev_valid = 1'b0;
  logic       clr_req = 1'b0;
  logic [7:0] last_good = 8'h00;

  always @(negedge clk) begin
    if (clr_req) begin
      got_q.delete(); got_t.delete(); got_busy.delete();
      got_fe_t.delete(); fe_data.delete();
      dbl_cnt = 0; both_cnt = 0;
    end else begin
      if (ifc.rx_data_valid) begin
        got_q.push_back(ifc.data_in_rx);
        got_t.push_back(cyc);
        got_busy.push_back(ifc.rx_busy);
      end
      if (ifc.frame_err) begin
        got_fe_t.push_back(cyc);
        fe_data.push_back(ifc.data_in_rx);
      end
      if (ifc.rx_data_valid && prev_valid) dbl_cnt++;
      if (ifc.rx_data_valid && ifc.frame_err) both_cnt++;
    end
    prev_valid = ifc.rx_data_valid;
  end

  // Downstream assembler model: rising-edge detect on the strobe, little-endian packing.
  logic        asm_we = 1'b0;
  logic        asm_clr = 1'b0;
  logic        asm_vd = 1'b0;
  logic [31:0] asm_instr = '0;
  logic [31:0] asm_addr = '0;
  int          asm_cnt = 0;

  always @(posedge clk) begin
    asm_vd <= ifc.rx_data_valid;
    if (asm_clr) begin
      asm_cnt   <= 0;
      asm_instr <= '0;
      asm_addr  <= '0;
    end else if (asm_we && ifc.rx_data_valid && !asm_vd) begin
      if (asm_cnt < 4) asm_instr[asm_cnt*8 +: 8] <= ifc.data_in_rx;
      else if (asm_cnt < 8) asm_addr[(asm_cnt-4)*8 +: 8] <= ifc.data_in_rx;
      asm_cnt <= asm_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete(); exp_t.delete(); exp_fe_t.delete();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
  endtask

  // Drives the first nsym symbols of an 8N1 frame (start, d[0..7], stop), CPB cycles each.
  task automatic drive_frame(input logic [7:0] d, input logic stop, input int nsym, output int t0);
    logic [9:0] f;
    f  = {stop, d, 1'b0};
    t0 = cyc;
    for (int i = 0; i < nsym; i++) begin
      ifc.rx = f[i];
      repeat (CPB) step();
    end
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    int t0;
    drive_frame(d, stop, 10, t0);
    if (stop) begin
      exp_q.push_back(d);
      exp_t.push_back(t0 + LAT);
      last_good = d;
    end else begin
      exp_fe_t.push_back(t0 + LAT);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.rx = 1'b1;
    repeat (4) step();
    n_checks++; if (ifc.data_in_rx !== 8'h00) $display("FAIL reset_data: got %h expected 00", ifc.data_in_rx); else n_pass++;
    n_checks++; if (ifc.rx_data_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", ifc.rx_data_valid); else n_pass++;
    n_checks++; if (ifc.frame_err !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", ifc.frame_err); else n_pass++;
    n_checks++; if (ifc.rx_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", ifc.rx_busy); else n_pass++;
    rst = 1'b0;
    last_good = 8'h00;
    repeat (5) step();
  endtask

  task automatic test_single();
    clear_sb();
    send(8'hA5, 1'b1);
    repeat (20) step();
    n_checks++; if (got_q.size() != 1) $display("FAIL single_count: got %0d expected 1", got_q.size()); else n_pass++;
    if (got_q.size() > 0) begin
      n_checks++; if (got_q[0] !== 8'hA5) $display("FAIL single_data: got %h expected a5", got_q[0]); else n_pass++;
      n_checks++; if (got_t[0] != exp_t[0]) $display("FAIL single_time: got %0d expected %0d", got_t[0], exp_t[0]); else n_pass++;
      n_checks++; if (got_busy[0] !== 1'b0) $display("FAIL single_busy: got %b expected 0", got_busy[0]); else n_pass++;
    end
    n_checks++; if (dbl_cnt != 0) $display("FAIL single_width: got %0d long pulses expected 0", dbl_cnt); else n_pass++;
    n_checks++; if (got_fe_t.size() != 0) $display("FAIL single_ferr: got %0d expected 0", got_fe_t.size()); else n_pass++;
    n_checks++; if (ifc.data_in_rx !== 8'hA5) $display("FAIL single_hold: got %h expected a5", ifc.data_in_rx); else n_pass++;
  endtask

  task automatic test_back_to_back();
    clear_sb();
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    repeat (20) step();
    n_checks++; if (got_q.size() != 2) $display("FAIL b2b_count: got %0d expected 2", got_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL b2b_data%0d: got %h expected %h", i, got_q[i], exp_q[i]); else n_pass++;
      n_checks++; if (got_t[i] != exp_t[i]) $display("FAIL b2b_time%0d: got %0d expected %0d", i, got_t[i], exp_t[i]); else n_pass++;
    end
    if (got_t.size() == 2) begin
      n_checks++; if (got_t[1] - got_t[0] != 160) $display("FAIL b2b_spacing: got %0d expected 160", got_t[1] - got_t[0]); else n_pass++;
    end
    n_checks++; if (got_fe_t.size() != 0) $display("FAIL b2b_ferr: got %0d expected 0", got_fe_t.size()); else n_pass++;
  endtask

  task automatic test_glitch();
    int t0;
    logic [7:0] prior;
    clear_sb();
    prior = last_good;
    ifc.rx = 1'b0;
    t0 = cyc;
    repeat (3) step();
    ifc.rx = 1'b1;
    while (cyc < t0 + 3 + HALF - 1) step();
    n_checks++; if (ifc.rx_busy !== 1'b1) $display("FAIL glitch_busy_mid: got %b expected 1", ifc.rx_busy); else n_pass++;
    step();
    n_checks++; if (ifc.rx_busy !== 1'b0) $display("FAIL glitch_idle: got %b expected 0", ifc.rx_busy); else n_pass++;
    repeat (40) step();
    n_checks++; if (got_q.size() != 0) $display("FAIL glitch_valid: got %0d expected 0", got_q.size()); else n_pass++;
    n_checks++; if (got_fe_t.size() != 0) $display("FAIL glitch_ferr: got %0d expected 0", got_fe_t.size()); else n_pass++;
    n_checks++; if (ifc.data_in_rx !== prior) $display("FAIL glitch_data: got %h expected %h", ifc.data_in_rx, prior); else n_pass++;
  endtask

  task automatic test_frame_err();
    logic [7:0] prior;
    clear_sb();
    prior = last_good;
    send(8'h3C, 1'b0);
    repeat (40) step();
    n_checks++; if (got_q.size() != 0) $display("FAIL ferr_no_rx_low: got %0d expected 0", got_q.size()); else n_pass++;
    ifc.rx = 1'b1;
    repeat (5) step();
    send(8'h55, 1'b1);
    repeat (20) step();
    n_checks++; if (got_fe_t.size() != 1) $display("FAIL ferr_count: got %0d expected 1", got_fe_t.size()); else n_pass++;
    if (got_fe_t.size() > 0) begin
      n_checks++; if (got_fe_t[0] != exp_fe_t[0]) $display("FAIL ferr_time: got %0d expected %0d", got_fe_t[0], exp_fe_t[0]); else n_pass++;
      n_checks++; if (fe_data[0] !== prior) $display("FAIL ferr_data_held: got %h expected %h", fe_data[0], prior); else n_pass++;
    end
    n_checks++; if (got_q.size() != 1) $display("FAIL ferr_next_count: got %0d expected 1", got_q.size()); else n_pass++;
    if (got_q.size() > 0) begin
      n_checks++; if (got_q[0] !== 8'h55) $display("FAIL ferr_next_data: got %h expected 55", got_q[0]); else n_pass++;
    end
    n_checks++; if (both_cnt != 0) $display("FAIL ferr_overlap: got %0d expected 0", both_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int t0;
    clear_sb();
    drive_frame(8'h96, 1'b1, 5, t0);
    ifc.rx = 1'b1;
    repeat (CPB / 2) step();
    rst = 1'b1;
    step();
    n_checks++; if (ifc.data_in_rx !== 8'h00) $display("FAIL rstmid_data: got %h expected 00", ifc.data_in_rx); else n_pass++;
    n_checks++; if (ifc.rx_data_valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", ifc.rx_data_valid); else n_pass++;
    n_checks++; if (ifc.frame_err !== 1'b0) $display("FAIL rstmid_ferr: got %b expected 0", ifc.frame_err); else n_pass++;
    n_checks++; if (ifc.rx_busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", ifc.rx_busy); else n_pass++;
    rst = 1'b0;
    last_good = 8'h00;
    repeat (200) step();
    n_checks++; if (got_q.size() + got_fe_t.size() != 0) $display("FAIL rstmid_no_pulse: got %0d expected 0", got_q.size() + got_fe_t.size()); else n_pass++;
    send(8'h12, 1'b1);
    repeat (20) step();
    n_checks++; if (got_q.size() != 1) $display("FAIL rstmid_next_count: got %0d expected 1", got_q.size()); else n_pass++;
    if (got_q.size() > 0) begin
      n_checks++; if (got_q[0] !== 8'h12) $display("FAIL rstmid_next_data: got %h expected 12", got_q[0]); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       stop;
    clear_sb();
    for (int f = 0; f < 16; f++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      send(d, stop);
      if (!stop) begin
        repeat ($urandom_range(0, 30)) step();
        ifc.rx = 1'b1;
        repeat ($urandom_range(2, 12)) step();
      end else begin
        repeat ($urandom_range(0, 12)) step();
      end
    end
    repeat (20) step();
    n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL rand_data%0d: got %h expected %h", i, got_q[i], exp_q[i]); else n_pass++;
      n_checks++; if (got_t[i] != exp_t[i]) $display("FAIL rand_time%0d: got %0d expected %0d", i, got_t[i], exp_t[i]); else n_pass++;
    end
    n_checks++; if (got_fe_t.size() != exp_fe_t.size()) $display("FAIL rand_ferr_count: got %0d expected %0d", got_fe_t.size(), exp_fe_t.size()); else n_pass++;
    for (int i = 0; i < exp_fe_t.size() && i < got_fe_t.size(); i++) begin
      n_checks++; if (got_fe_t[i] != exp_fe_t[i]) $display("FAIL rand_ferr_time%0d: got %0d expected %0d", i, got_fe_t[i], exp_fe_t[i]); else n_pass++;
    end
    n_checks++; if (dbl_cnt + both_cnt != 0) $display("FAIL rand_pulse_shape: got %0d expected 0", dbl_cnt + both_cnt); else n_pass++;
    n_checks++; if (ifc.data_in_rx !== last_good) $display("FAIL rand_hold: got %h expected %h", ifc.data_in_rx, last_good); else n_pass++;
  endtask

  task automatic test_integration();
    logic [7:0] stream [8];
    stream = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00};
    clear_sb();
    asm_clr = 1'b1;
    step();
    asm_clr = 1'b0;
    asm_we  = 1'b1;
    for (int i = 0; i < 8; i++) send(stream[i], 1'b1);
    repeat (20) step();
    asm_we = 1'b0;
    n_checks++; if (asm_instr !== 32'h00100093) $display("FAIL integ_instr: got %h expected 00100093", asm_instr); else n_pass++;
    n_checks++; if (asm_addr !== 32'h00000010) $display("FAIL integ_addr: got %h expected 00000010", asm_addr); else n_pass++;
    n_checks++; if (asm_cnt != 8) $display("FAIL integ_bytes: got %0d expected 8", asm_cnt); else n_pass++;
  endtask

  initial begin
    ifc.rx = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_random();
    test_integration();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Bounds the run even if a task stalls.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish before cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- Serial UART receiver feeding the instruction-write path.
- Samples the asynchronous rx line, deframes 8N1 characters (LSB first), and presents each byte on data_in_rx with a one-cycle rx_data_valid strobe.
- The instruction-write assembler consumes these outputs, edge-detects the strobe, and packs bytes into instruction/address words.
- The block also reports framing errors and busy status.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, line bit rate in baud.
- Derived, not overridable: CPB = CLK_FREQ / BAUD_RATE (integer divide; CPB >= 8 required, elaboration error otherwise).
- Derived, not overridable: HALF = CPB / 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- data_in_rx  output  8  last correctly framed byte; held until the next good byte.
- rx_data_valid  output  1  one-cycle pulse when data_in_rx updates.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. No asynchronous reset anywhere.
- Input synchronizer: rx passes through two flops. Both flops reset to 1. Call the result rxs; all decisions use rxs only.
- Reset values: data_in_rx=8'h00, rx_data_valid=0, frame_err=0, rx_busy=0, state=IDLE, bit counter=0, cycle counter=0, shift register=0.
- Reset mid-frame: abandons the frame immediately. No valid or error pulse is produced for that frame.
- State machine, states IDLE, START, DATA, STOP, WAIT_HIGH:
  - IDLE: cycle counter held at 0. When rxs==0, go to START. Call this edge T0.
  - START: count cycles. When count reaches HALF-1: if rxs==0, go to DATA with cycle counter=0 and bit index=0. If rxs==1, treat it as a glitch and go to IDLE; no outputs pulse.
  - DATA: count 0..CPB-1. At count==CPB-1, shift rxs into bit[bit index] (LSB first) and reset the count. After bit index 7 is sampled, go to STOP.
  - STOP: count 0..CPB-1 and sample at CPB-1.
    - If rxs==1: load data_in_rx from the shift register, pulse rx_data_valid for exactly 1 cycle, go to IDLE.
    - If rxs==0: pulse frame_err for 1 cycle, leave data_in_rx unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs==1, then go to IDLE. This prevents a break condition from retriggering reception.
- Sample timing: mid-bit sample k occurs H + k*CPB cycles after T0, where k=0 is start, 1..8 are data, 9 is stop, and H=HALF.
- Output latency: rx_data_valid and data_in_rx become visible the cycle after the stop sample edge.
- Back-to-back characters: returning to IDLE at the stop-bit midpoint allows a start bit immediately after a one-bit stop to be caught. A falling edge within the remaining half stop bit is accepted.
- Pulse spacing: rx_data_valid is never high on two consecutive cycles. Consecutive strobes are at least 9*CPB cycles apart, so a downstream rising-edge detector sees each byte once.
- Mutual exclusion: rx_data_valid and frame_err are never high in the same cycle.
- Counter widths: cycle counter is wide enough for CPB-1 (use $clog2(CPB)); bit index is 3 bits. There is no wrap beyond the states above.

Test Plan:
- Sim parameters: CLK_FREQ=1_600_000, BAUD_RATE=100_000, giving CPB=16 and HALF=8.
- Single byte: drive 0xA5 as 8N1 at 16 clk/bit. Required: rx_data_valid high for exactly 1 cycle, data_in_rx=8'hA5, frame_err never high, rx_busy low again after the stop sample.
- Back-to-back: send 0x00 then 0xFF with a one-bit stop and no idle gap. Required: two valid pulses, values 8'h00 then 8'hFF, pulses 160 cycles apart, no frame_err.
- Glitch rejection: pull rx low for 3 cycles, then return high. Required: returns to IDLE after HALF, no rx_data_valid, no frame_err, data_in_rx unchanged.
- Framing error: send 0x3C with stop bit 0, hold rx low 40 more cycles, then send 0x55 normally. Required: one frame_err pulse, data_in_rx stays at its prior value, no reception during the low hold, then valid with 8'h55.
- Reset mid-frame: assert rst for 1 cycle during data bit 4 of 0x96, then send 0x12. Required: all outputs read their reset values the cycle after rst, no pulse for 0x96, valid with 8'h12.
- Downstream integration: stream bytes 93 00 10 00 10 00 00 00 into the instruction-write assembler with its write-enable set. Required: instruction word 32'h00100093, address 32'h00000010, and exactly eight accepted bytes.
